// File: rtl/stream_frame_assembler.sv
// stream_frame_assembler
// Collects a time-multiplexed sample stream (stream 0 flagged by s_first)
// into a parallel frame vector for temporal_fusion, pulsing x_valid once
// per completed frame and flagging/counting framing errors.
module stream_frame_assembler #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_STREAMS = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [DATA_WIDTH-1:0]          s_data,
  input  logic                                  s_valid,
  input  logic                                  s_first,
  output logic                                  s_ready,
  output logic [0:NUM_STREAMS-1][DATA_WIDTH-1:0] x_out,
  output logic                                  x_valid,
  output logic [CNT_WIDTH-1:0]                  frame_count,
  output logic                                  sync_err,
  output logic [CNT_WIDTH-1:0]                  sync_err_count
);

  localparam int IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STREAMS - 1);

  typedef enum logic {
    EXPECT_FIRST,
    FILL
  } state_t;

  state_t                                  state, state_next;
  logic [IDX_W-1:0]                        idx, idx_next;
  logic [0:NUM_STREAMS-1][DATA_WIDTH-1:0]  fill_buf;
  logic [0:NUM_STREAMS-1][DATA_WIDTH-1:0]  frame_next;
  logic                                    accept;
  logic                                    wr_en;
  logic [IDX_W-1:0]                        wr_idx;
  logic                                    complete;
  logic                                    err;

  assign accept = s_valid && s_ready;

  // FSM state and write index register.
  // NOTE: sequential state is always assigned with <= so every register in
  // the block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EXPECT_FIRST;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state decode: where the accepted sample goes, and whether it
  // completes a frame or signals a framing error.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    wr_en      = 1'b0;
    wr_idx     = idx;
    complete   = 1'b0;
    err        = 1'b0;
    unique case (state)
      EXPECT_FIRST: begin
        if (accept) begin
          if (s_first) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            if (NUM_STREAMS == 1) begin
              complete = 1'b1;
            end else begin
              idx_next   = IDX_W'(1);
              state_next = FILL;
            end
          end else begin
            // Stray mid-frame sample with no frame open: drop it.
            err = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (s_first) begin
            // Premature start: abandon the partial frame, restart on this sample.
            err      = 1'b1;
            wr_idx   = '0;
            idx_next = IDX_W'(1);
          end else if (idx == LAST_IDX) begin
            complete   = 1'b1;
            idx_next   = '0;
            state_next = EXPECT_FIRST;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_next = EXPECT_FIRST;
        idx_next   = '0;
      end
    endcase
  end

  // Fill buffer with the incoming sample merged into its slot; this is also
  // the frame presented on completion.
  always_comb begin
    frame_next = fill_buf;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) frame_next[i] = s_data;
    end
  end

  // Frame buffer storage.
  // NOTE: the buffer is deliberately not reset; a frame is only emitted
  // after every slot has been rewritten starting from slot 0, so stale
  // contents can never escape.
  always_ff @(posedge clk) begin
    if (wr_en) fill_buf <= frame_next;
  end

  // Output frame, pulses, handshake and saturating status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready        <= 1'b0;
      x_out          <= '0;
      x_valid        <= 1'b0;
      sync_err       <= 1'b0;
      frame_count    <= '0;
      sync_err_count <= '0;
    end else begin
      s_ready  <= 1'b1;
      x_valid  <= complete;
      sync_err <= err;
      if (complete) begin
        x_out <= frame_next;
        if (frame_count != '1) frame_count <= frame_count + CNT_WIDTH'(1);
      end
      if (err && (sync_err_count != '1)) begin
        sync_err_count <= sync_err_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_frame_assembler.sv
// Self-checking bench for stream_frame_assembler: a 4-stream instance under
// directed and random stimulus against a queue-based frame model, a
// 2-bit-counter instance for saturation, and a 1-stream instance.
module tb_stream_frame_assembler;

  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Shared stimulus for the 4-stream instances.
  logic signed [W-1:0] s_data  = '0;
  logic                s_valid = 1'b0;
  logic                s_first = 1'b0;

  logic                    s_ready, x_valid, sync_err;
  logic [0:N-1][W-1:0]     x_out;
  logic [15:0]             frame_count, sync_err_count;

  logic                    sat_ready, sat_xv, sat_se;
  logic [0:N-1][W-1:0]     sat_x;
  logic [1:0]              sat_fc, sat_ec;

  // Single-stream instance stimulus and outputs.
  logic signed [W-1:0] s1_data  = '0;
  logic                s1_valid = 1'b0;
  logic                s1_first = 1'b0;
  logic                s1_ready, s1_xv, s1_se;
  logic [0:0][W-1:0]   s1_x;
  logic [15:0]         s1_fc, s1_ec;

  int assert_count = 0;
  int fail_count   = 0;

  // Reference model state.
  logic [W-1:0]   partial[$];
  logic [63:0]    exp_x;
  logic           exp_xv, exp_se, exp_ready;
  int             exp_fc, exp_ec;
  int             pulse_count;
  string          phase;

  always #5 clk = ~clk;

  stream_frame_assembler #(.DATA_WIDTH(W), .NUM_STREAMS(N), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_first(s_first),
    .s_ready(s_ready), .x_out(x_out), .x_valid(x_valid), .frame_count(frame_count),
    .sync_err(sync_err), .sync_err_count(sync_err_count)
  );

  stream_frame_assembler #(.DATA_WIDTH(W), .NUM_STREAMS(N), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_first(s_first),
    .s_ready(sat_ready), .x_out(sat_x), .x_valid(sat_xv), .frame_count(sat_fc),
    .sync_err(sat_se), .sync_err_count(sat_ec)
  );

  stream_frame_assembler #(.DATA_WIDTH(W), .NUM_STREAMS(1), .CNT_WIDTH(16)) dut_one (
    .clk(clk), .rst(rst), .s_data(s1_data), .s_valid(s1_valid), .s_first(s1_first),
    .s_ready(s1_ready), .x_out(s1_x), .x_valid(s1_xv), .frame_count(s1_fc),
    .sync_err(s1_se), .sync_err_count(s1_ec)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("FAIL %s [%s]: observed %h expected %h", tag, phase, observed, expected);
    end
  endtask

  function automatic int sat(input int value, input int limit);
    return (value > limit) ? limit : value;
  endfunction

  // One clock: apply inputs, advance the model by the frame rules, then
  // compare every 4-stream output just after the edge.
  task automatic step(input logic v, input logic f, input logic [W-1:0] d);
    s_valid = v;
    s_first = f;
    s_data  = d;
    @(posedge clk);
    if (rst) begin
      partial.delete();
      exp_x = '0; exp_xv = 1'b0; exp_se = 1'b0;
      exp_fc = 0; exp_ec = 0; exp_ready = 1'b0;
    end else begin
      exp_xv = 1'b0;
      exp_se = 1'b0;
      if (v && exp_ready) begin
        if (f) begin
          if (partial.size() != 0) begin exp_se = 1'b1; exp_ec++; end
          partial.delete();
          partial.push_back(d);
        end else if (partial.size() == 0) begin
          exp_se = 1'b1; exp_ec++;
        end else begin
          partial.push_back(d);
        end
        if (partial.size() == N) begin
          exp_x  = {partial[0], partial[1], partial[2], partial[3]};
          exp_xv = 1'b1;
          exp_fc++;
          partial.delete();
        end
      end
      exp_ready = 1'b1;
    end
    #1;
    if (x_valid) pulse_count++;
    check("s_ready", 64'(s_ready), 64'(exp_ready));
    check("x_valid", 64'(x_valid), 64'(exp_xv));
    check("sync_err", 64'(sync_err), 64'(exp_se));
    check("x_out", x_out, exp_x);
    check("frame_count", 64'(frame_count), 64'(sat(exp_fc, 65535)));
    check("sync_err_count", 64'(sync_err_count), 64'(sat(exp_ec, 65535)));
    check("sat_frame_count", 64'(sat_fc), 64'(sat(exp_fc, 3)));
    check("no_overlap", 64'(x_valid && sync_err), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] e, input bit gaps);
    logic [W-1:0] vals[4];
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = e;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) step(1'b0, 1'b0, W'($urandom));
      end
      step(1'b1, (i == 0), vals[i]);
    end
  endtask

  initial begin
    logic [63:0] held;
    logic [W-1:0] d;
    pulse_count = 0;
    exp_x = '0; exp_xv = 1'b0; exp_se = 1'b0; exp_ready = 1'b0;
    exp_fc = 0; exp_ec = 0;

    // Reset, then the cycle after release must still refuse samples.
    phase = "reset";
    do_reset();
    check("ready_in_reset", 64'(s_ready), 64'(0));
    check("x_out_reset", x_out, 64'(0));
    step(1'b1, 1'b1, 16'h1234);   // offered while s_ready is still 0: ignored
    check("ready_after_release", 64'(s_ready), 64'(1));

    phase = "first_frame";
    pulse_count = 0;
    send_frame(16'd10, -16'sd20, 16'd30, -16'sd40, 1'b0);
    check("first_pulse_on_last", 64'(x_valid), 64'(1));
    check("first_x_out", x_out, {16'd10, -16'sd20, 16'd30, -16'sd40});
    check("first_frame_count", 64'(frame_count), 64'(1));
    step(1'b0, 1'b0, '0);
    check("first_single_pulse", 64'(pulse_count), 64'(1));

    phase = "gapped_frames";
    pulse_count = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b1);
      held = x_out;
      for (int k = 0; k < 2; k++) step(1'b0, 1'b0, W'($urandom));
      check("x_out_stable", x_out, held);
    end
    check("gapped_pulses", 64'(pulse_count), 64'(3));
    check("sat_at_3", 64'(sat_fc), 64'(3));

    phase = "premature_start";
    do_reset();
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 16'd1);
    step(1'b1, 1'b0, 16'd2);
    step(1'b1, 1'b1, 16'd7);
    check("premature_pulse", 64'(sync_err), 64'(1));
    step(1'b1, 1'b0, 16'd8);
    step(1'b1, 1'b0, 16'd9);
    step(1'b1, 1'b0, 16'd10);
    check("premature_frame", x_out, {16'd7, 16'd8, 16'd9, 16'd10});
    check("premature_err_count", 64'(sync_err_count), 64'(1));
    check("premature_frame_count", 64'(frame_count), 64'(1));

    phase = "stray_samples";
    do_reset();
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 16'd5);
    step(1'b1, 1'b0, 16'd6);
    send_frame(16'd100, 16'd200, 16'd300, 16'd400, 1'b0);
    check("stray_err_count", 64'(sync_err_count), 64'(2));
    check("stray_frame_count", 64'(frame_count), 64'(1));
    check("stray_x_out", x_out, {16'd100, 16'd200, 16'd300, 16'd400});

    phase = "reset_mid_frame";
    step(1'b1, 1'b1, 16'd55);
    step(1'b1, 1'b0, 16'd66);
    do_reset();
    check("rst_frame_count", 64'(frame_count), 64'(0));
    check("rst_err_count", 64'(sync_err_count), 64'(0));
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 16'd77);   // needs s_first after reset: error, not a slot
    send_frame(-16'sd1, -16'sd2, -16'sd3, -16'sd4, 1'b0);
    check("rst_x_out", x_out, {-16'sd1, -16'sd2, -16'sd3, -16'sd4});
    check("rst_after_frame_count", 64'(frame_count), 64'(1));

    // Random stream: mostly well-formed, with occasional flipped s_first.
    phase = "random";
    for (int i = 0; i < 300; i++) begin
      logic natural_first;
      natural_first = (partial.size() == 0);
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0) ? !natural_first : natural_first,
           W'($urandom));
    end

    // Single-stream instance: every accepted first sample is a frame.
    phase = "single_stream";
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
      s1_valid = 1'b1; s1_first = 1'b1; s1_data = d;
      step(1'b0, 1'b0, '0);
      check("one_x_valid", 64'(s1_xv), 64'(1));
      check("one_x_out", 64'(s1_x), 64'(d));
      check("one_frame_count", 64'(s1_fc), 64'(i + 1));
      check("one_sync_err", 64'(s1_se), 64'(0));
    end
    s1_first = 1'b0; s1_data = 16'h0042;
    step(1'b0, 1'b0, '0);
    check("one_err_pulse", 64'(s1_se), 64'(1));
    check("one_err_no_frame", 64'(s1_xv), 64'(0));
    check("one_err_count", 64'(s1_ec), 64'(1));
    check("one_x_out_held", 64'(s1_x), 64'(16'h8000));
    s1_valid = 1'b0;
    step(1'b0, 1'b0, '0);
    check("one_idle", 64'(s1_xv), 64'(0));
    check("one_idle_err", 64'(s1_se), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/stream_frame_assembler.md
Name: stream_frame_assembler

Overview:
Upstream stage of temporal_fusion. It accepts a time-multiplexed scalar sample stream, one stream sample per beat, in stream order 0..NUM_STREAMS-1, with a start-of-frame marker on stream 0. It collects one sample per stream into a frame buffer. When a frame is complete it presents the frame as a parallel vector, with a one-cycle x_valid pulse that drives temporal_fusion's x_in/x_valid directly. It also detects and counts framing errors.

Parameters:
DATA_WIDTH, 16, sample width (signed).
NUM_STREAMS, 4, samples per frame; legal range >= 1.
CNT_WIDTH, 16, width of the status counters.

Ports:
clk  input  1  clock.
rst  input  1  synchronous, active-high reset.
s_data  input  DATA_WIDTH signed  serial sample.
s_valid  input  1  s_data valid.
s_first  input  1  marks the stream-0 sample of a frame; qualified by s_valid.
s_ready  output  1  sample accepted when s_valid && s_ready.
x_out  output  [0:NUM_STREAMS-1] x DATA_WIDTH signed  assembled frame vector.
x_valid  output  1  one-cycle pulse, x_out holds a new frame.
frame_count  output  CNT_WIDTH  frames emitted; saturating.
sync_err  output  1  one-cycle pulse on a framing error.
sync_err_count  output  CNT_WIDTH  framing errors; saturating.

Behaviour:
- Reset (rst sampled high at posedge):
  - x_out all 0; x_valid, sync_err, s_ready 0; both counters 0.
  - State goes to EXPECT_FIRST; idx = 0.
- s_ready is registered: 0 during reset and on the first cycle after rst deasserts, 1 thereafter. There is no downstream backpressure.
- "Accept" means s_valid && s_ready at a posedge.
- Internal state: fill buffer buf[0:NUM_STREAMS-1], write index idx (clog2 width, min 1 bit), FSM states EXPECT_FIRST and FILL.
- EXPECT_FIRST, accept with s_first=1:
  - buf[0] <= s_data.
  - If NUM_STREAMS==1, the frame completes on this beat; otherwise idx <= 1 and go to FILL.
- EXPECT_FIRST, accept with s_first=0:
  - Sample dropped; pulse sync_err; sync_err_count++.
  - Stay in EXPECT_FIRST.
- FILL, accept with s_first=0:
  - buf[idx] <= s_data.
  - If idx==NUM_STREAMS-1, the frame completes, idx <= 0, go to EXPECT_FIRST; else idx++.
- FILL, accept with s_first=1 (premature start):
  - Partial frame discarded; pulse sync_err; sync_err_count++.
  - The sample is kept as the new frame start: buf[0] <= s_data, idx <= 1, stay in FILL.
- Frame completion on the accept at edge N:
  - At edge N, x_out <= buf with the completing sample substituted in its slot, and x_valid <= 1.
  - x_out/x_valid are visible in cycle N+1, i.e. one cycle latency from the last accepted sample.
  - frame_count++ in the same edge.
- x_valid is high for exactly one cycle per frame. x_out holds its value until the next completion.
  - Back-to-back frames at 1 sample/cycle give a pulse every NUM_STREAMS cycles. For NUM_STREAMS==1 the pulse is continuous.
- No-accept cycles (s_valid=0) leave all state unchanged; gaps mid-frame are legal.
- Counters stop at 2^CNT_WIDTH-1 and do not wrap. They increment in the same edge as the corresponding pulse.
- sync_err and x_valid never assert together for NUM_STREAMS>1. For NUM_STREAMS==1 there is no FILL state, so errors occur only on s_first=0.
- Reset mid-frame discards the partial frame; the next frame requires s_first.
- Data is stored bit-exact; no arithmetic or width conversion.

Test Plan:
- Reset → s_ready=0 for 2 cycles. Then send frame first=1 {10,-20,30,-40} back-to-back → x_valid pulses once, exactly 1 cycle after the -40 beat; x_out={10,-20,30,-40}; frame_count=1; sync_err never asserted.
- Three back-to-back frames with random s_valid gaps inside frames → 3 pulses, each frame bit-exact, frame_count=3, x_out stable between pulses.
- Frame {1,2} then s_first=1 with 7, then {8,9,10} → one sync_err pulse, sync_err_count=1, single frame {7,8,9,10} emitted.
- After reset send 5,6 with s_first=0, then a valid frame {100,200,300,400} → sync_err_count=2, frame_count=1, x_out={100,200,300,400}.
- Assert rst after 2 of 4 samples, release, send full frame {-1,-2,-3,-4} → no x_valid from the partial frame, counters 0 after reset, then one frame {-1,-2,-3,-4}.
- CNT_WIDTH=2, 5 frames → frame_count saturates at 3. NUM_STREAMS=1, s_first=1 every cycle with 0x7FFF,0x8000 → x_valid continuous, x_out follows with 1-cycle latency.
